fifo_sync_flex: RTL and testbench

Single-clock FIFO: the parametrised successor of the dual-clock FIFO for same-domain buffering.
- Any depth, not only powers of two.
- Selectable standard or first-word-fall-through (FWFT) read mode.
- Fill-level count, programmable almost-full and almost-empty thresholds.
- Synchronous flush and sticky overflow/underflow error flags.
- Used between pipeline stages and in front of DMA/packet engines that need occupancy and back-pressure information.

---
 rtl/fifo_sync_flex.sv | 158 +++++++++++++++
 tb/tb_fifo_sync_flex.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_flex.sv
// Single-clock FIFO of arbitrary depth with optional first-word-fall-through output,
// occupancy count, almost-full/almost-empty thresholds, flush and sticky error flags.
module fifo_sync_flex #(
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 1024,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = DEPTH - 4,
  parameter int AEMPTY_THRESH = 4,
  localparam int CNT_WIDTH    = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int PTR_WIDTH = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] DEPTH_C  = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] AFULL_C  = CNT_WIDTH'(AFULL_THRESH);
  localparam logic [CNT_WIDTH-1:0] AEMPTY_C = CNT_WIDTH'(AEMPTY_THRESH);
  localparam logic [PTR_WIDTH-1:0] PTR_LAST = PTR_WIDTH'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [CNT_WIDTH-1:0]  cnt_nxt;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  ovf_evt;
  logic                  udf_evt;
  logic                  mem_rd;
  logic                  empty_nxt;

  // Pointers wrap at DEPTH-1 so any depth works; occupancy lives in count.
  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_WIDTH'(1);
  endfunction

  always_comb begin
    rd_acc  = !flush && rd_en && !empty;
    wr_acc  = !flush && wr_en && (!full || rd_acc);
    ovf_evt = !flush && wr_en && full && !rd_acc;
    udf_evt = !flush && rd_en && empty;
    cnt_nxt = count;
    if (flush) begin
      cnt_nxt = '0;
    end else if (wr_acc && !rd_acc) begin
      cnt_nxt = count + CNT_WIDTH'(1);
    end else if (rd_acc && !wr_acc) begin
      cnt_nxt = count - CNT_WIDTH'(1);
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // rd_data acts as a one-word prefetch stage; count covers it plus the RAM.
      logic out_valid;
      logic valid_nxt;

      always_comb begin
        mem_rd    = !flush && (count != CNT_WIDTH'(out_valid)) && (!out_valid || rd_acc);
        valid_nxt = out_valid;
        if (flush) begin
          valid_nxt = 1'b0;
        end else if (mem_rd) begin
          valid_nxt = 1'b1;
        end else if (rd_acc) begin
          valid_nxt = 1'b0;
        end
        empty_nxt = !valid_nxt;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid <= 1'b0;
        end else begin
          out_valid <= valid_nxt;
        end
      end
    end else begin : g_std
      always_comb begin
        mem_rd    = rd_acc;
        empty_nxt = (cnt_nxt == '0);
      end
    end
  endgenerate

  // No reset on the array so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      rd_data      <= '0;
    end else begin
      count        <= cnt_nxt;
      full         <= (cnt_nxt == DEPTH_C);
      empty        <= empty_nxt;
      almost_full  <= (cnt_nxt >= AFULL_C);
      almost_empty <= (cnt_nxt <= AEMPTY_C);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_acc) begin
          wr_ptr <= ptr_inc(wr_ptr);
        end
        if (mem_rd) begin
          rd_ptr <= ptr_inc(rd_ptr);
        end
      end
      if (mem_rd) begin
        rd_data <= mem[rd_ptr];
      end
    end
  end

  // A new error in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_evt) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (udf_evt) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_sync_flex.sv
// Directed bench for fifo_sync_flex: one standard-mode and one FWFT instance, depth 5.
module tb_fifo_sync_flex;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic       s_flush = 1'b0, s_wr_en = 1'b0, s_rd_en = 1'b0, s_clr_err = 1'b0;
  logic [7:0] s_wr_data = 8'h00;
  logic       s_full, s_af, s_empty, s_ae, s_ovf, s_udf;
  logic [7:0] s_rd_data;
  logic [2:0] s_count;

  logic       f_flush = 1'b0, f_wr_en = 1'b0, f_rd_en = 1'b0, f_clr_err = 1'b0;
  logic [7:0] f_wr_data = 8'h00;
  logic       f_full, f_af, f_empty, f_ae, f_ovf, f_udf;
  logic [7:0] f_rd_data;
  logic [2:0] f_count;

  // flags = {empty, full, almost_empty, almost_full, overflow, underflow}
  wire [5:0] s_flags = {s_empty, s_full, s_ae, s_af, s_ovf, s_udf};
  wire [5:0] f_flags = {f_empty, f_full, f_ae, f_af, f_ovf, f_udf};

  fifo_sync_flex #(.DATA_WIDTH(8), .DEPTH(5), .FWFT(0), .AFULL_THRESH(4), .AEMPTY_THRESH(1)) u_std (
    .clk(clk), .rst_n(rst_n), .flush(s_flush), .wr_en(s_wr_en), .wr_data(s_wr_data),
    .full(s_full), .almost_full(s_af), .rd_en(s_rd_en), .rd_data(s_rd_data),
    .empty(s_empty), .almost_empty(s_ae), .count(s_count), .overflow(s_ovf),
    .underflow(s_udf), .clr_err(s_clr_err)
  );

  fifo_sync_flex #(.DATA_WIDTH(8), .DEPTH(5), .FWFT(1), .AFULL_THRESH(4), .AEMPTY_THRESH(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .flush(f_flush), .wr_en(f_wr_en), .wr_data(f_wr_data),
    .full(f_full), .almost_full(f_af), .rd_en(f_rd_en), .rd_data(f_rd_data),
    .empty(f_empty), .almost_empty(f_ae), .count(f_count), .overflow(f_ovf),
    .underflow(f_udf), .clr_err(f_clr_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic s_idle();
    s_flush = 1'b0; s_wr_en = 1'b0; s_rd_en = 1'b0; s_clr_err = 1'b0;
  endtask

  task automatic f_idle();
    f_flush = 1'b0; f_wr_en = 1'b0; f_rd_en = 1'b0; f_clr_err = 1'b0;
  endtask

  task automatic s_write(input logic [7:0] d);
    s_idle(); s_wr_en = 1'b1; s_wr_data = d; step(); s_idle();
  endtask

  task automatic f_write(input logic [7:0] d);
    f_idle(); f_wr_en = 1'b1; f_wr_data = d; step(); f_idle();
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (s_count !== 3'd0) begin n_err++; $display("FAIL std_reset_count: got %0d exp 0", s_count); end
    n_cmp++; if (s_flags !== 6'b101000) begin n_err++; $display("FAIL std_reset_flags: got %b exp 101000", s_flags); end
    n_cmp++; if (s_rd_data !== 8'h00) begin n_err++; $display("FAIL std_reset_rd_data: got %h exp 00", s_rd_data); end
    n_cmp++; if (f_count !== 3'd0) begin n_err++; $display("FAIL fwft_reset_count: got %0d exp 0", f_count); end
    n_cmp++; if (f_flags !== 6'b101000) begin n_err++; $display("FAIL fwft_reset_flags: got %b exp 101000", f_flags); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_std_fill();
    s_write(8'h11);
    n_cmp++; if (s_count !== 3'd1) begin n_err++; $display("FAIL std_fill1_count: got %0d exp 1", s_count); end
    n_cmp++; if (s_flags !== 6'b001000) begin n_err++; $display("FAIL std_fill1_flags: got %b exp 001000", s_flags); end
    for (int i = 1; i < 5; i++) s_write(8'h11 + 8'(i));
    n_cmp++; if (s_count !== 3'd5) begin n_err++; $display("FAIL std_full_count: got %0d exp 5", s_count); end
    n_cmp++; if (s_flags !== 6'b010100) begin n_err++; $display("FAIL std_full_flags: got %b exp 010100", s_flags); end
    s_write(8'h66);
    n_cmp++; if (s_count !== 3'd5) begin n_err++; $display("FAIL std_ovf_count: got %0d exp 5", s_count); end
    n_cmp++; if (s_flags !== 6'b010110) begin n_err++; $display("FAIL std_ovf_flags: got %b exp 010110", s_flags); end
  endtask

  task automatic test_std_drain();
    for (int i = 0; i < 5; i++) begin
      s_idle(); s_rd_en = 1'b1; step(); s_idle();
      n_cmp++; if (s_rd_data !== 8'h11 + 8'(i)) begin n_err++; $display("FAIL std_drain_data[%0d]: got %h exp %h", i, s_rd_data, 8'h11 + 8'(i)); end
    end
    n_cmp++; if (s_count !== 3'd0) begin n_err++; $display("FAIL std_drain_count: got %0d exp 0", s_count); end
    n_cmp++; if (s_flags !== 6'b101010) begin n_err++; $display("FAIL std_drain_flags: got %b exp 101010", s_flags); end
    s_clr_err = 1'b1; step(); s_idle();
    n_cmp++; if (s_flags !== 6'b101000) begin n_err++; $display("FAIL std_clr_ovf_flags: got %b exp 101000", s_flags); end
  endtask

  task automatic test_std_wrap();
    for (int i = 0; i < 5; i++) s_write(8'h21 + 8'(i));
    n_cmp++; if (s_count !== 3'd5) begin n_err++; $display("FAIL std_wrap_count: got %0d exp 5", s_count); end
    for (int i = 0; i < 5; i++) begin
      s_idle(); s_rd_en = 1'b1; step(); s_idle();
      n_cmp++; if (s_rd_data !== 8'h21 + 8'(i)) begin n_err++; $display("FAIL std_wrap_data[%0d]: got %h exp %h", i, s_rd_data, 8'h21 + 8'(i)); end
    end
    n_cmp++; if (s_flags !== 6'b101000) begin n_err++; $display("FAIL std_wrap_flags: got %b exp 101000", s_flags); end
  endtask

  task automatic test_std_simul();
    for (int i = 0; i < 5; i++) s_write(8'h31 + 8'(i));
    s_idle(); s_wr_en = 1'b1; s_wr_data = 8'h36; s_rd_en = 1'b1; step(); s_idle();
    n_cmp++; if (s_count !== 3'd5) begin n_err++; $display("FAIL std_full_rw_count: got %0d exp 5", s_count); end
    n_cmp++; if (s_rd_data !== 8'h31) begin n_err++; $display("FAIL std_full_rw_data: got %h exp 31", s_rd_data); end
    n_cmp++; if (s_flags !== 6'b010100) begin n_err++; $display("FAIL std_full_rw_flags: got %b exp 010100", s_flags); end
    for (int i = 0; i < 5; i++) begin
      s_idle(); s_rd_en = 1'b1; step(); s_idle();
      n_cmp++; if (s_rd_data !== 8'h32 + 8'(i)) begin n_err++; $display("FAIL std_rw_drain[%0d]: got %h exp %h", i, s_rd_data, 8'h32 + 8'(i)); end
    end
    s_idle(); s_wr_en = 1'b1; s_wr_data = 8'h40; s_rd_en = 1'b1; step(); s_idle();
    n_cmp++; if (s_count !== 3'd1) begin n_err++; $display("FAIL std_empty_rw_count: got %0d exp 1", s_count); end
    n_cmp++; if (s_rd_data !== 8'h36) begin n_err++; $display("FAIL std_empty_rw_data: got %h exp 36", s_rd_data); end
    n_cmp++; if (s_flags !== 6'b001001) begin n_err++; $display("FAIL std_empty_rw_flags: got %b exp 001001", s_flags); end
    s_rd_en = 1'b1; step(); s_idle();
    n_cmp++; if (s_rd_data !== 8'h40) begin n_err++; $display("FAIL std_empty_rw_readback: got %h exp 40", s_rd_data); end
  endtask

  task automatic test_err_clear();
    s_idle(); s_rd_en = 1'b1; s_clr_err = 1'b1; step(); s_idle();
    n_cmp++; if (s_flags !== 6'b101001) begin n_err++; $display("FAIL std_clr_vs_set: got %b exp 101001", s_flags); end
    n_cmp++; if (s_rd_data !== 8'h40) begin n_err++; $display("FAIL std_udf_rd_data_held: got %h exp 40", s_rd_data); end
    s_clr_err = 1'b1; step(); s_idle();
    n_cmp++; if (s_flags !== 6'b101000) begin n_err++; $display("FAIL std_clr_udf: got %b exp 101000", s_flags); end
  endtask

  task automatic test_std_flush();
    for (int i = 0; i < 3; i++) s_write(8'h51 + 8'(i));
    s_idle(); s_flush = 1'b1; s_wr_en = 1'b1; s_wr_data = 8'h99; s_rd_en = 1'b1; step(); s_idle();
    n_cmp++; if (s_count !== 3'd0) begin n_err++; $display("FAIL std_flush_count: got %0d exp 0", s_count); end
    n_cmp++; if (s_flags !== 6'b101000) begin n_err++; $display("FAIL std_flush_flags: got %b exp 101000", s_flags); end
    n_cmp++; if (s_rd_data !== 8'h40) begin n_err++; $display("FAIL std_flush_rd_held: got %h exp 40", s_rd_data); end
    s_write(8'h7E);
    s_rd_en = 1'b1; step(); s_idle();
    n_cmp++; if (s_rd_data !== 8'h7E) begin n_err++; $display("FAIL std_post_flush_data: got %h exp 7e", s_rd_data); end
    n_cmp++; if (s_count !== 3'd0) begin n_err++; $display("FAIL std_post_flush_count: got %0d exp 0", s_count); end
  endtask

  task automatic test_fwft();
    f_write(8'hA0);
    n_cmp++; if (f_count !== 3'd1) begin n_err++; $display("FAIL fwft_lat1_count: got %0d exp 1", f_count); end
    n_cmp++; if (f_flags !== 6'b101000) begin n_err++; $display("FAIL fwft_lat1_flags: got %b exp 101000", f_flags); end
    step();
    n_cmp++; if (f_flags !== 6'b001000) begin n_err++; $display("FAIL fwft_lat2_flags: got %b exp 001000", f_flags); end
    n_cmp++; if (f_rd_data !== 8'hA0) begin n_err++; $display("FAIL fwft_first_word: got %h exp a0", f_rd_data); end
    for (int i = 1; i < 4; i++) f_write(8'hA0 + 8'(i));
    n_cmp++; if (f_count !== 3'd4) begin n_err++; $display("FAIL fwft_cnt4: got %0d exp 4", f_count); end
    n_cmp++; if (f_flags !== 6'b000100) begin n_err++; $display("FAIL fwft_cnt4_flags: got %b exp 000100", f_flags); end
    n_cmp++; if (f_rd_data !== 8'hA0) begin n_err++; $display("FAIL fwft_head_held: got %h exp a0", f_rd_data); end
    f_rd_en = 1'b1; step(); f_idle();
    n_cmp++; if (f_rd_data !== 8'hA1) begin n_err++; $display("FAIL fwft_pop_data: got %h exp a1", f_rd_data); end
    n_cmp++; if (f_count !== 3'd3) begin n_err++; $display("FAIL fwft_pop_count: got %0d exp 3", f_count); end
    f_write(8'hA4);
    f_write(8'hA5);
    n_cmp++; if (f_flags !== 6'b010100) begin n_err++; $display("FAIL fwft_full_flags: got %b exp 010100", f_flags); end
    f_wr_en = 1'b1; f_wr_data = 8'hA6; f_rd_en = 1'b1; step(); f_idle();
    n_cmp++; if (f_count !== 3'd5) begin n_err++; $display("FAIL fwft_full_rw_count: got %0d exp 5", f_count); end
    n_cmp++; if (f_rd_data !== 8'hA2) begin n_err++; $display("FAIL fwft_full_rw_data: got %h exp a2", f_rd_data); end
    n_cmp++; if (f_flags !== 6'b010100) begin n_err++; $display("FAIL fwft_full_rw_flags: got %b exp 010100", f_flags); end
    f_write(8'hA7);
    n_cmp++; if (f_flags !== 6'b010110) begin n_err++; $display("FAIL fwft_ovf_flags: got %b exp 010110", f_flags); end
    for (int i = 0; i < 4; i++) begin
      f_rd_en = 1'b1; step(); f_idle();
      n_cmp++; if (f_rd_data !== 8'hA3 + 8'(i)) begin n_err++; $display("FAIL fwft_drain[%0d]: got %h exp %h", i, f_rd_data, 8'hA3 + 8'(i)); end
    end
    f_rd_en = 1'b1; step(); f_idle();
    n_cmp++; if (f_count !== 3'd0) begin n_err++; $display("FAIL fwft_drain_count: got %0d exp 0", f_count); end
    n_cmp++; if (f_flags !== 6'b101010) begin n_err++; $display("FAIL fwft_drain_flags: got %b exp 101010", f_flags); end
    f_clr_err = 1'b1; step(); f_idle();
    f_wr_en = 1'b1; f_wr_data = 8'hB0; f_rd_en = 1'b1; step(); f_idle();
    n_cmp++; if (f_count !== 3'd1) begin n_err++; $display("FAIL fwft_empty_rw_count: got %0d exp 1", f_count); end
    n_cmp++; if (f_flags !== 6'b101001) begin n_err++; $display("FAIL fwft_empty_rw_flags: got %b exp 101001", f_flags); end
    step();
    n_cmp++; if (f_rd_data !== 8'hB0) begin n_err++; $display("FAIL fwft_empty_rw_data: got %h exp b0", f_rd_data); end
    f_write(8'hB1);
    f_write(8'hB2);
    f_flush = 1'b1; f_wr_en = 1'b1; f_wr_data = 8'h99; f_rd_en = 1'b1; step(); f_idle();
    n_cmp++; if (f_count !== 3'd0) begin n_err++; $display("FAIL fwft_flush_count: got %0d exp 0", f_count); end
    n_cmp++; if (f_flags !== 6'b101001) begin n_err++; $display("FAIL fwft_flush_flags: got %b exp 101001", f_flags); end
    f_write(8'h7E);
    step();
    n_cmp++; if (f_rd_data !== 8'h7E) begin n_err++; $display("FAIL fwft_post_flush_data: got %h exp 7e", f_rd_data); end
    n_cmp++; if (f_flags !== 6'b001001) begin n_err++; $display("FAIL fwft_post_flush_flags: got %b exp 001001", f_flags); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) s_write(8'h61 + 8'(i));
    s_rd_en = 1'b1; step(); s_idle();
    n_cmp++; if (s_count !== 3'd3) begin n_err++; $display("FAIL rst_pre_count: got %0d exp 3", s_count); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (s_count !== 3'd0) begin n_err++; $display("FAIL rst_async_count: got %0d exp 0", s_count); end
    n_cmp++; if (s_flags !== 6'b101000) begin n_err++; $display("FAIL rst_async_flags: got %b exp 101000", s_flags); end
    n_cmp++; if (s_rd_data !== 8'h00) begin n_err++; $display("FAIL rst_async_rd_data: got %h exp 00", s_rd_data); end
    n_cmp++; if (f_flags !== 6'b101000) begin n_err++; $display("FAIL rst_async_fwft_flags: got %b exp 101000", f_flags); end
    #2 rst_n = 1'b1;
    s_write(8'h5A);
    s_rd_en = 1'b1; step(); s_idle();
    n_cmp++; if (s_rd_data !== 8'h5A) begin n_err++; $display("FAIL rst_new_word: got %h exp 5a", s_rd_data); end
    n_cmp++; if (s_flags !== 6'b101000) begin n_err++; $display("FAIL rst_post_flags: got %b exp 101000", s_flags); end
  endtask

  initial begin
    test_reset();
    test_std_fill();
    test_std_drain();
    test_std_wrap();
    test_std_simul();
    test_err_clear();
    test_std_flush();
    test_fwft();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
